// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable sequence detector family
package seq_det_pkg;
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL = 1'b1;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1010;
  localparam int DEF_LEN = 4;
  localparam logic DEF_OVERLAP = MODE_NONOVL;
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign q = cnt_q;
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with Mealy/registered hits and hit counter
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int RST_LEN = DEF_LEN,
  parameter logic RST_OVERLAP = DEF_OVERLAP,
  localparam int LW = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic               y_reg,
  output logic [CNT_W-1:0]   hit_cnt
);
  logic [MAX_LEN-1:0] pat_q, pat_d, win, mask;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0] len_q, len_d, fill_q, fill_d;
  logic ovl_q, ovl_d, y_reg_q, match;
  assign win = {hist_q, x};
  // only the low len_q bits of the window and pattern take part in the compare
  assign mask = ~({MAX_LEN{1'b1}} << len_q);
  assign match = (len_q != '0) && (fill_q >= len_q - 1'b1) && (((win ^ pat_q) & mask) == '0);
  assign y = x_valid & match & ~cfg_load & ~rst;
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
      ovl_d = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      hist_d = win[MAX_LEN-2:0];
      // non-overlap hits restart the fill so no matched bit is reused
      fill_d = (y && ovl_q == MODE_NONOVL) ? '0 :
               (fill_q == LW'(MAX_LEN - 1)) ? fill_q : fill_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= RST_PATTERN;
      len_q <= LW'(RST_LEN);
      ovl_q <= RST_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      y_reg_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_reg_q <= y;
    end
  end
  assign y_reg = y_reg_q;
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .clr(rst),
    .inc(y),
    .q(hit_cnt)
  );
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed-vector self-checking bench for seq_detect_prog (CNT_W = 4)
module tb_seq_detect_prog;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0;
  logic x_valid = 1'b0;
  logic cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic cfg_overlap = 1'b0;
  logic y, y_reg;
  logic [3:0] hit_cnt;
  int checks = 0;
  int errors = 0;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .x_valid(x_valid),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .y(y),
    .y_reg(y_reg),
    .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    cfg_load = 1'b0;
    x = 1'b0;
    x_valid = 1'b1;
    #1 chk({tag, " y in rst"}, 32'(y), 0);
    @(posedge clk);
    #1 chk({tag, " cnt after rst"}, 32'(hit_cnt), 0);
    chk({tag, " y_reg after rst"}, 32'(y_reg), 0);
    @(negedge clk);
    rst = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    @(negedge clk);
    x_valid = 1'b0;
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_y, input string tag, input int idx);
    @(negedge clk);
    x = b;
    x_valid = 1'b1;
    #1 chk($sformatf("%s y bit%0d", tag, idx), 32'(y), 32'(exp_y));
    @(posedge clk);
    #1 chk($sformatf("%s y_reg bit%0d", tag, idx), 32'(y_reg), 32'(exp_y));
  endtask

  // bits[n-1] is sent first; hits[i] is the expected y for bits[i]
  task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] hits, input string tag);
    for (int i = n - 1; i >= 0; i--) send(bits[i], hits[i], tag, n - i);
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic idle_toggle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      x_valid = 1'b0;
      x = ~x;
      #1 chk({tag, " idle y"}, 32'(y), 0);
    end
  endtask

  initial begin
    do_reset("rst0");
    chk("default y", 32'(y), 0);
    stream(32'b1010_1010, 8, 32'b0001_0001, "nonovl8");
    chk("nonovl8 cnt", 32'(hit_cnt), 2);
    do_reset("rst1");
    stream(32'b10_1010, 6, 32'b00_0100, "nonovl6");
    chk("nonovl6 cnt", 32'(hit_cnt), 1);

    do_reset("rst2");
    load(8'b0000_1010, 4'd4, 1'b1);
    stream(32'b10_1010, 6, 32'b00_0101, "ovl6");
    chk("ovl6 cnt", 32'(hit_cnt), 2);
    load(8'b1101_1011, 4'd8, 1'b1);
    stream(32'b110_1101_1011, 11, 32'b000_0000_1001, "ovl11");
    chk("ovl11 cnt kept over load", 32'(hit_cnt), 4);

    do_reset("rst3");
    send(1'b1, 1'b0, "gap", 1);
    idle_toggle(3, "gap1");
    send(1'b0, 1'b0, "gap", 2);
    idle_toggle(3, "gap2");
    send(1'b1, 1'b0, "gap", 3);
    idle_toggle(3, "gap3");
    send(1'b0, 1'b1, "gap", 4);
    idle_toggle(3, "gap4");
    chk("gap cnt", 32'(hit_cnt), 1);

    do_reset("rst4");
    stream(32'b101, 3, 32'b000, "pre_load");
    load(8'b0000_1010, 4'd4, 1'b0);
    stream(32'b0_1010, 5, 32'b0_0001, "post_load");
    chk("mid load cnt", 32'(hit_cnt), 1);

    do_reset("rst5");
    stream(32'b101, 3, 32'b000, "pre_rst");
    do_reset("rst_mid");
    stream(32'b0, 1, 32'b0, "post_rst");
    chk("mid rst cnt", 32'(hit_cnt), 0);

    do_reset("rst6");
    stream(32'b101, 3, 32'b000, "pre_sim");
    @(negedge clk);
    x = 1'b0;
    x_valid = 1'b1;
    cfg_load = 1'b1;
    cfg_pattern = 8'b0000_1010;
    cfg_len = 4'd4;
    cfg_overlap = 1'b0;
    #1 chk("sim load y", 32'(y), 0);
    @(posedge clk);
    #1 chk("sim load cnt", 32'(hit_cnt), 0);
    chk("sim load y_reg", 32'(y_reg), 0);
    cfg_load = 1'b0;
    x_valid = 1'b0;
    stream(32'b1010, 4, 32'b0001, "after_sim");
    chk("after sim cnt", 32'(hit_cnt), 1);

    do_reset("rst7");
    load(8'b0000_0000, 4'd0, 1'b1);
    stream(32'b1010_1010, 8, 32'b0, "len0 a");
    stream(32'b0000_0000, 8, 32'b0, "len0 b");
    stream(32'b1111_1111, 8, 32'b0, "len0 c");
    chk("len0 cnt", 32'(hit_cnt), 0);

    do_reset("rst8");
    load(8'b1011_0011, 4'd15, 1'b0);
    stream(32'b0011_0011_1011_0011, 16, 32'h0001, "len15");
    chk("len15 cnt", 32'(hit_cnt), 1);

    do_reset("rst9");
    load(8'b0000_0001, 4'd1, 1'b1);
    stream(32'hF_FFFF, 20, 32'hF_FFFF, "sat");
    chk("sat cnt", 32'(hit_cnt), 15);
    stream(32'b1, 1, 32'b1, "sat more");
    chk("sat hold", 32'(hit_cnt), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
